// File: rtl/reg_pkg.sv
// reg_pkg: shared defaults and sizing helper for the reg_pipe slice
package reg_pkg;

    localparam int DATAWIDTH_DEFAULT = 64;
    localparam int DEPTH_DEFAULT     = 4;

    // Width of an occupancy counter that must represent 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one valid bit plus data register of the elastic pipeline
module reg_pipe_stage
    import reg_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Flush,
    input  logic                 load,
    input  logic                 src_valid,
    input  logic [DATAWIDTH-1:0] src_data,
    output logic                 valid,
    output logic [DATAWIDTH-1:0] data
);

    // Load the valid bit on enable; data only follows a valid source so it never picks up garbage
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (Flush) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid)
                data <= src_data;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: elastic DEPTH-stage pipeline register with valid/ready handshake and flush
module reg_pipe
    import reg_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATAWIDTH-1:0]          d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATAWIDTH-1:0]          q,
    output logic [count_width(DEPTH)-1:0] Count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0]     v;
    logic [DEPTH-1:0]     move;
    logic [DEPTH-1:0]     accept;
    logic [DATAWIDTH-1:0] r [DEPTH];
    logic                 down;

    // Ready chain walked from the output end: a stage moves when downstream takes it, accepts when empty or moving
    always_comb begin
        move   = '0;
        accept = '0;
        down   = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            move[k]   = v[k] & down;
            accept[k] = ~v[k] | move[k];
            down      = accept[k];
        end
    end

    assign in_ready = accept[0] & ~Flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            reg_pipe_stage #(.DATAWIDTH(DATAWIDTH)) u_stage (
                .Clk       (Clk),
                .Rst       (Rst),
                .Flush     (Flush),
                .load      (accept[0]),
                .src_valid (in_valid & in_ready),
                .src_data  (d),
                .valid     (v[0]),
                .data      (r[0])
            );
        end else begin : g_body
            reg_pipe_stage #(.DATAWIDTH(DATAWIDTH)) u_stage (
                .Clk       (Clk),
                .Rst       (Rst),
                .Flush     (Flush),
                .load      (accept[k]),
                .src_valid (move[k-1]),
                .src_data  (r[k-1]),
                .valid     (v[k]),
                .data      (r[k])
            );
        end
    end

    assign out_valid = v[DEPTH-1];
    assign q         = r[DEPTH-1];

    // Occupancy is the popcount of the registered stage valid bits
    always_comb begin
        Count = '0;
        for (int k = 0; k < DEPTH; k++)
            Count = Count + CW'(v[k]);
    end

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed and randomized checks of reg_pipe (DEPTH=4/64b and DEPTH=1/8b) against a positional queue model
module tb_reg_pipe;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][2:0]  pos;
        logic [3:0][63:0] dat;
    } model_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        fl4, iv4, ordy4, irdy4, ov4;
    logic [63:0] d4, q4;
    logic [2:0]  c4;
    logic        fl1, iv1, ordy1, irdy1, ov1;
    logic [7:0]  d1, q1;
    logic        c1;
    model_t      m4, m1;
    int          n_chk = 0;
    int          n_fail = 0;

    reg_pipe #(.DATAWIDTH(64), .DEPTH(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Flush(fl4), .in_valid(iv4), .in_ready(irdy4), .d(d4),
        .out_valid(ov4), .out_ready(ordy4), .q(q4), .Count(c4)
    );

    reg_pipe #(.DATAWIDTH(8), .DEPTH(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .Flush(fl1), .in_valid(iv1), .in_ready(irdy1), .d(d1),
        .out_valid(ov1), .out_ready(ordy1), .q(q1), .Count(c1)
    );

    always #5 Clk = ~Clk;

    // One clock of the reference: words are an ordered list with a stage position; each advances if the slot ahead frees up
    function automatic model_t advance(model_t m, int depth, logic ivld, logic ordy, logic fl, logic [63:0] din);
        model_t r;
        int a, np;
        r = '0;
        if (fl) return r;
        a = ordy ? depth + 1 : depth;
        for (int i = 0; i < int'(m.n); i++) begin
            np = (int'(m.pos[i]) + 1 < a) ? int'(m.pos[i]) + 1 : int'(m.pos[i]);
            a = np;
            if (np < depth) begin
                r.pos[r.n] = 3'(np);
                r.dat[r.n] = m.dat[i];
                r.n = r.n + 3'd1;
            end
        end
        if (ivld && a > 0) begin
            r.pos[r.n] = 3'd0;
            r.dat[r.n] = din;
            r.n = r.n + 3'd1;
        end
        return r;
    endfunction

    function automatic logic exp_rdy(model_t m, int depth, logic ordy, logic fl);
        int a;
        a = ordy ? depth + 1 : depth;
        for (int i = 0; i < int'(m.n); i++)
            a = (int'(m.pos[i]) + 1 < a) ? int'(m.pos[i]) + 1 : int'(m.pos[i]);
        return !fl && a > 0;
    endfunction

    function automatic logic exp_ov(model_t m, int depth);
        return m.n != 3'd0 && int'(m.pos[0]) == depth - 1;
    endfunction

    task automatic tick();
        @(posedge Clk);
        m4 = advance(m4, 4, iv4, ordy4, fl4, d4);
        m1 = advance(m1, 1, iv1, ordy1, fl1, {56'd0, d1});
        #1;
    endtask

    task automatic test_reset();
        #1 Rst = 1'b1;
        #1;
        n_chk++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_ov4: got %b want 0", ov4); end
        n_chk++; if (q4 !== 64'd0) begin n_fail++; $display("FAIL reset_q4: got %0h want 0", q4); end
        n_chk++; if (c4 !== 3'd0) begin n_fail++; $display("FAIL reset_count4: got %0d want 0", c4); end
        n_chk++; if (ov1 !== 1'b0 || q1 !== 8'd0 || c1 !== 1'b0) begin n_fail++; $display("FAIL reset_dut1: got ov=%b q=%0h c=%b want 0/0/0", ov1, q1, c1); end
        @(negedge Clk);
        Rst = 1'b0;
        m4 = '0;
        m1 = '0;
        #1;
        n_chk++; if (irdy4 !== 1'b1 || irdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b/%b want 1/1", irdy4, irdy1); end
        tick();
        iv4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d4 = 64'(100 + i);
            tick();
        end
        iv4 = 1'b0;
        @(negedge Clk);
        n_chk++; if (c4 !== 3'd4 || ov4 !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got c=%0d ov=%b want 4/1", c4, ov4); end
        Rst = 1'b1;
        #1;
        n_chk++; if (c4 !== 3'd0 || ov4 !== 1'b0 || q4 !== 64'd0) begin n_fail++; $display("FAIL midreset_clear: got c=%0d ov=%b q=%0h want 0/0/0", c4, ov4, q4); end
        m4 = '0;
        #1 Rst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        ordy4 = 1'b1;
        for (int c = 0; c < 13; c++) begin
            iv4 = c < 8;
            d4 = 64'(c + 1);
            @(negedge Clk);
            if (c < 8) begin
                n_chk++; if (irdy4 !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, irdy4); end
            end
            n_chk++; if (ov4 !== (c >= 4 && c < 12)) begin n_fail++; $display("FAIL stream_ov c=%0d: got %b want %b", c, ov4, (c >= 4 && c < 12)); end
            if (c >= 4 && c < 12) begin
                n_chk++; if (q4 !== 64'(c - 3)) begin n_fail++; $display("FAIL stream_q c=%0d: got %0h want %0h", c, q4, c - 3); end
            end
            tick();
        end
        iv4 = 1'b0;
    endtask

    task automatic test_backpressure();
        ordy4 = 1'b0;
        iv4 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            d4 = (c < 4) ? 64'(c + 1) : 64'd5;
            @(negedge Clk);
            n_chk++; if (irdy4 !== (c < 4)) begin n_fail++; $display("FAIL bp_in_ready c=%0d: got %b want %b", c, irdy4, c < 4); end
            if (c >= 4) begin
                n_chk++; if (c4 !== 3'd4 || ov4 !== 1'b1 || q4 !== 64'd1) begin n_fail++; $display("FAIL bp_full c=%0d: got c=%0d ov=%b q=%0h want 4/1/1", c, c4, ov4, q4); end
            end
            tick();
        end
        ordy4 = 1'b1;
        @(negedge Clk);
        n_chk++; if (irdy4 !== 1'b1 || ov4 !== 1'b1 || q4 !== 64'd1) begin n_fail++; $display("FAIL bp_release: got rdy=%b ov=%b q=%0h want 1/1/1", irdy4, ov4, q4); end
        tick();
        iv4 = 1'b0;
        for (int j = 2; j <= 5; j++) begin
            @(negedge Clk);
            n_chk++; if (ov4 !== 1'b1 || q4 !== 64'(j)) begin n_fail++; $display("FAIL bp_drain: got ov=%b q=%0h want 1/%0h", ov4, q4, j); end
            tick();
        end
        @(negedge Clk);
        n_chk++; if (c4 !== 3'd0 || ov4 !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got c=%0d ov=%b want 0/0", c4, ov4); end
        tick();
    endtask

    task automatic test_full_pushpop();
        ordy4 = 1'b0;
        iv4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d4 = 64'(21 + i);
            tick();
        end
        ordy4 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            d4 = 64'(25 + j);
            @(negedge Clk);
            n_chk++; if (irdy4 !== 1'b1 || c4 !== 3'd4) begin n_fail++; $display("FAIL full_pp j=%0d: got rdy=%b c=%0d want 1/4", j, irdy4, c4); end
            n_chk++; if (ov4 !== 1'b1 || q4 !== 64'(21 + j)) begin n_fail++; $display("FAIL full_pp_q j=%0d: got ov=%b q=%0h want 1/%0h", j, ov4, q4, 21 + j); end
            tick();
        end
        iv4 = 1'b0;
        for (int j = 6; j < 10; j++) begin
            @(negedge Clk);
            n_chk++; if (ov4 !== 1'b1 || q4 !== 64'(21 + j)) begin n_fail++; $display("FAIL full_drain j=%0d: got ov=%b q=%0h want 1/%0h", j, ov4, q4, 21 + j); end
            tick();
        end
        @(negedge Clk);
        n_chk++; if (c4 !== 3'd0) begin n_fail++; $display("FAIL full_empty: got %0d want 0", c4); end
        tick();
    endtask

    task automatic test_flush();
        int seen;
        ordy4 = 1'b0;
        iv4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d4 = 64'(41 + i);
            tick();
        end
        d4 = 64'd99;
        fl4 = 1'b1;
        @(negedge Clk);
        n_chk++; if (irdy4 !== 1'b0 || c4 !== 3'd3) begin n_fail++; $display("FAIL flush_cycle: got rdy=%b c=%0d want 0/3", irdy4, c4); end
        tick();
        fl4 = 1'b0;
        iv4 = 1'b0;
        @(negedge Clk);
        n_chk++; if (c4 !== 3'd0 || ov4 !== 1'b0 || q4 !== 64'd0) begin n_fail++; $display("FAIL flush_after: got c=%0d ov=%b q=%0h want 0/0/0", c4, ov4, q4); end
        tick();
        ordy4 = 1'b1;
        iv4 = 1'b1;
        d4 = 64'd50;
        tick();
        iv4 = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (ov4 === 1'b1) begin
                seen++;
                n_chk++; if (q4 !== 64'd50) begin n_fail++; $display("FAIL flush_leak: got %0h want 50", q4); end
            end
            tick();
        end
        n_chk++; if (seen !== 1) begin n_fail++; $display("FAIL flush_post_word: got %0d outputs want 1", seen); end
    endtask

    task automatic test_depth1();
        logic [7:0] prev;
        ordy1 = 1'b1;
        iv1 = 1'b1;
        d1 = 8'hA5;
        @(negedge Clk);
        n_chk++; if (irdy1 !== 1'b1 || ov1 !== 1'b0) begin n_fail++; $display("FAIL d1_first: got rdy=%b ov=%b want 1/0", irdy1, ov1); end
        tick();
        prev = 8'hA5;
        for (int j = 0; j < 5; j++) begin
            d1 = 8'(8'h10 + j);
            @(negedge Clk);
            n_chk++; if (ov1 !== 1'b1 || q1 !== prev) begin n_fail++; $display("FAIL d1_q j=%0d: got ov=%b q=%0h want 1/%0h", j, ov1, q1, prev); end
            n_chk++; if (irdy1 !== 1'b1 || c1 !== 1'b1) begin n_fail++; $display("FAIL d1_rdy j=%0d: got rdy=%b c=%b want 1/1", j, irdy1, c1); end
            prev = d1;
            tick();
        end
        ordy1 = 1'b0;
        d1 = 8'h77;
        @(negedge Clk);
        n_chk++; if (irdy1 !== 1'b0 || q1 !== prev) begin n_fail++; $display("FAIL d1_stall: got rdy=%b q=%0h want 0/%0h", irdy1, q1, prev); end
        tick();
        ordy1 = 1'b1;
        iv1 = 1'b0;
        @(negedge Clk);
        n_chk++; if (ov1 !== 1'b1 || q1 !== prev) begin n_fail++; $display("FAIL d1_hold: got ov=%b q=%0h want 1/%0h", ov1, q1, prev); end
        tick();
        @(negedge Clk);
        n_chk++; if (ov1 !== 1'b0 || c1 !== 1'b0) begin n_fail++; $display("FAIL d1_empty: got ov=%b c=%b want 0/0", ov1, c1); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            iv4 = 1'($urandom_range(0, 1));
            ordy4 = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl4 = $urandom_range(0, 24) == 0;
            d4 = {$urandom, $urandom};
            iv1 = 1'($urandom_range(0, 1));
            ordy1 = 1'($urandom_range(0, 1));
            fl1 = $urandom_range(0, 24) == 0;
            d1 = 8'($urandom);
            @(negedge Clk);
            n_chk++; if (irdy4 !== exp_rdy(m4, 4, ordy4, fl4)) begin n_fail++; $display("FAIL rnd_rdy4 c=%0d: got %b want %b", c, irdy4, exp_rdy(m4, 4, ordy4, fl4)); end
            n_chk++; if (ov4 !== exp_ov(m4, 4)) begin n_fail++; $display("FAIL rnd_ov4 c=%0d: got %b want %b", c, ov4, exp_ov(m4, 4)); end
            n_chk++; if (c4 !== m4.n) begin n_fail++; $display("FAIL rnd_count4 c=%0d: got %0d want %0d", c, c4, m4.n); end
            if (exp_ov(m4, 4)) begin
                n_chk++; if (q4 !== m4.dat[0]) begin n_fail++; $display("FAIL rnd_q4 c=%0d: got %0h want %0h", c, q4, m4.dat[0]); end
            end
            n_chk++; if (irdy1 !== exp_rdy(m1, 1, ordy1, fl1)) begin n_fail++; $display("FAIL rnd_rdy1 c=%0d: got %b want %b", c, irdy1, exp_rdy(m1, 1, ordy1, fl1)); end
            n_chk++; if (ov1 !== exp_ov(m1, 1) || c1 !== m1.n[0]) begin n_fail++; $display("FAIL rnd_ov1 c=%0d: got ov=%b c=%b want %b/%b", c, ov1, c1, exp_ov(m1, 1), m1.n[0]); end
            if (exp_ov(m1, 1)) begin
                n_chk++; if (q1 !== m1.dat[0][7:0]) begin n_fail++; $display("FAIL rnd_q1 c=%0d: got %0h want %0h", c, q1, m1.dat[0][7:0]); end
            end
            tick();
        end
    endtask

    initial begin
        fl4 = 1'b0; iv4 = 1'b0; ordy4 = 1'b0; d4 = '0;
        fl1 = 1'b0; iv1 = 1'b0; ordy1 = 1'b0; d1 = '0;
        m4 = '0;
        m1 = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_pushpop();
        test_flush();
        test_depth1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
